// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: forwarding-select encodings and the in-flight tracker entry.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  // Tracker dst is sized for the widest supported register file; narrower addresses zero-extend.
  localparam int TRK_AW = 8;

  typedef struct packed {
    logic              valid;
    logic [TRK_AW-1:0] dst;
    logic              wr;
    logic              load;
  } trk_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Compares one decode source operand against one in-flight tracker entry.
module hazard_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  trk_entry_t        entry,
  output logic              hit
);

  logic unused_load;
  assign unused_load = entry.load;

  // Register 0 is hardwired, so writes to it never create a dependency.
  assign hit = use_src && entry.valid && entry.wr && (src != '0) &&
               (entry.dst == TRK_AW'(src));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: load-use / RAW stalls, operand forwarding selects and taken-branch flush window.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int BR_FLUSH_CYC = 1,
  parameter bit FWD_EN       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              ex_br_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  trk_entry_t ex_e, mem_e, wb_e;
  trk_entry_t ents [3];
  logic [2:0] hit_a, hit_b;  // index 0 = EX, 1 = MEM, 2 = WB
  logic [1:0] flush_ctr;
  logic       take, raw_stall, stall;

  assign ents[0] = ex_e;
  assign ents[1] = mem_e;
  assign ents[2] = wb_e;

  for (genvar g = 0; g < 3; g++) begin : g_match
    hazard_match #(.REG_AW(REG_AW)) u_a (
      .src(id_rs), .use_src(id_use_rs), .entry(ents[g]), .hit(hit_a[g]));
    hazard_match #(.REG_AW(REG_AW)) u_b (
      .src(id_rt), .use_src(id_use_rt), .entry(ents[g]), .hit(hit_b[g]));
  end

  // WB matches resolve through the write-before-read register file; they never stall or forward.
  logic unused_bits;
  assign unused_bits = ^{hit_a[2], hit_b[2], mem_e.load, wb_e.load};

  assign take = !rst && ex_br_taken && (flush_ctr == 2'd0);
  assign ifid_flush = !rst && (take || (flush_ctr != 2'd0));

  always_comb begin
    if (FWD_EN)
      raw_stall = id_valid && (hit_a[0] || hit_b[0]) && ex_e.load;
    else
      raw_stall = id_valid && ((|hit_a[1:0]) || (|hit_b[1:0]));
  end

  // A flush discards the decode instruction, so it overrides any stall request.
  assign stall       = !rst && raw_stall && !ifid_flush;
  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign idex_bubble = ifid_flush || stall;

  function automatic logic [1:0] sel_of(input logic ex_hit, input logic mem_hit);
    if (!FWD_EN || !id_valid || idex_bubble) return FWD_RF;
    if (ex_hit)  return FWD_EXMEM;
    if (mem_hit) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_e      <= '0;
      mem_e     <= '0;
      wb_e      <= '0;
      flush_ctr <= '0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      wb_e  <= mem_e;
      mem_e <= ex_e;
      if (idex_bubble)
        ex_e <= '0;
      else
        ex_e <= trk_entry_t'{valid: id_valid, dst: TRK_AW'(id_dst), wr: id_wr, load: id_load};

      if (take)
        flush_ctr <= 2'(BR_FLUSH_CYC - 1);
      else if (flush_ctr != 2'd0)
        flush_ctr <= flush_ctr - 2'd1;

      fwd_a_sel <= sel_of(hit_a[0], hit_a[1]);
      fwd_b_sel <= sel_of(hit_b[0], hit_b[1]);

      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (take && (flush_cnt != 16'hFFFF))  flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- REG_AW, 5, register-address width.
- BR_FLUSH_CYC, 1, cycles ifid_flush stays high after a taken branch (legal 1..3).
- FWD_EN, 1, 1 = forwarding mode; 0 = stall-only mode.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- id_valid, in, 1, a real instruction is in decode.
- id_rs, in, REG_AW, source A address.
- id_rt, in, REG_AW, source B address.
- id_use_rs, in, 1, instruction reads rs.
- id_use_rt, in, 1, instruction reads rt.
- id_dst, in, REG_AW, destination address after RegDst selection.
- id_wr, in, 1, instruction writes a register.
- id_load, in, 1, instruction is a load.
- ex_br_taken, in, 1, branch in EX is taken this cycle.
- pc_write, out, 1, PC update enable.
- ifid_write, out, 1, IF/ID register enable.
- ifid_flush, out, 1, clear IF/ID.
- idex_bubble, out, 1, load a NOP into ID/EX.
- fwd_a_sel, out, 2, operand-A source for the instruction in EX: 0 = register file, 1 = EX/MEM, 2 = MEM/WB.
- fwd_b_sel, out, 2, operand-B source, same encoding as fwd_a_sel.
- stall_cnt, out, 16, saturating count of stall cycles.
- flush_cnt, out, 16, saturating count of taken-branch events.

Function
REQ-003 The block SHALL keep a 3-entry in-flight tracker (EX, MEM, WB); each entry holds {valid, dst, wr, load} and shifts one place every clock.
REQ-004 The EX entry SHALL capture the decode fields when ID advances, and SHALL capture valid=0 when idex_bubble=1.
REQ-005 A source SHALL match an entry only when: the use bit is set, entry valid=1, entry wr=1, and dst equals the source address with dst != 0.
REQ-006 A load-use stall (FWD_EN=1) SHALL occur when id_valid=1 and a source matches the EX entry with load=1.
- During the stall: pc_write=0, ifid_write=0, idex_bubble=1.
REQ-007 In FWD_EN=0 mode, a stall SHALL occur on any source match with the EX or MEM entry; the WB entry never causes a stall because the register file is write-before-read.
REQ-008 fwd_a_sel and fwd_b_sel SHALL be registered; they are computed in ID and apply to that instruction when it is in EX.
- Match with the EX entry gives 1; match with the MEM entry gives 2.
- When both match, the EX entry wins (value 1).
- When there is no match, on a stall or bubble, or when FWD_EN=0, the value is 0.
REQ-009 On ex_br_taken=1 with the flush counter at 0:
- ifid_flush=1 and idex_bubble=1 in the same cycle;
- the counter loads BR_FLUSH_CYC-1;
- ifid_flush stays high while the counter is nonzero, and the counter decrements each cycle.
REQ-010 ex_br_taken asserted while the flush counter is nonzero SHALL be ignored; flush_cnt SHALL NOT increment for it.
REQ-011 When a flush and a stall coincide, the flush SHALL win: pc_write=1, ifid_write=1, stall_cnt unchanged.
REQ-012 stall_cnt SHALL increment on each stall cycle and flush_cnt on each accepted taken branch; both SHALL saturate at 16'hFFFF.
REQ-013 All remaining outputs SHALL be combinational from the current inputs and the registered state.

Reset
REQ-014 A cycle with rst=1 SHALL produce, on the next edge:
- all tracker entries invalid;
- flush counter = 0;
- fwd selects = 0;
- stall_cnt = 0 and flush_cnt = 0.
REQ-015 While rst=1, outputs SHALL be: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0. A reset in the middle of a flush window or a stall SHALL abort it.

Structure
REQ-016 The fwd-select encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB) and the tracker-entry struct SHALL live in the shared pipeline package.
REQ-017 One sub-module, hazard_match, SHALL implement REQ-005 and be instantiated once per (source, entry) pair.

Verification
REQ-018 The bench SHALL cover these scenarios:
- add $3 then sub $4,$3,$5 (FWD_EN=1) -> no stall; fwd_a_sel=1 with sub in EX.
- lw $2 then add $6,$2,$2 -> exactly one cycle with pc_write=0 and idex_bubble=1; then fwd_a_sel=fwd_b_sel=2; stall_cnt=1.
- Writer to $0 followed by a reader of $0 -> fwd selects 0, no stall.
- ex_br_taken plus a simultaneous load-use condition, BR_FLUSH_CYC=3 -> ifid_flush high 3 cycles, pc_write=1 throughout, second ex_br_taken inside the window ignored, flush_cnt=1.
- FWD_EN=0, add $3 then or $7,$3,$1 -> 2 stall cycles, selects stay 0.
- rst mid-flush -> ifid_flush=0 next cycle; counters read 0.
